// File: rtl/my_rx_pkg.sv
// Shared types and widths for the receive-side stream buffer.
// Imported by my_rx_fifo_mem and my_rx_buffer.
package my_rx_pkg;

  localparam int DATA_W = 12;
  localparam int CSUM_W = 16;

  typedef logic [DATA_W-1:0] rx_data_t;
  typedef logic [CSUM_W-1:0] rx_csum_t;

endpackage

// File: rtl/my_rx_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the control logic in my_rx_buffer masks stale data.
module my_rx_fifo_mem
  import my_rx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rx_data_t      wdata,
  input  logic [AW-1:0] raddr,
  output rx_data_t      rdata
);

  rx_data_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/my_rx_buffer.sv
// Receive buffer for a valid-only stream: FWFT FIFO with overflow tracking.
// Define MY_RX_BUFFER_CSUM_EN to build the running checksum of pushed beats.
module my_rx_buffer
  import my_rx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  rx_data_t                 in_data,
  input  logic                     in_vld,
  output rx_data_t                 out_data,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr,
  output rx_csum_t                 csum
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  rx_data_t      rdata;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          cnt_sat;

  assign full    = (level_q == LW'(DEPTH));
  assign out_vld = (level_q != '0);
  assign pop     = out_vld && out_rdy;
  assign push    = in_vld && (!full || pop);
  assign drop    = in_vld && full && !pop;
  assign cnt_sat = (drop_cnt == '1);

  my_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Storage is unreset, so present zero whenever the head is not valid.
  assign out_data = out_vld ? rdata : '0;
  assign level    = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      unique case (1'b1)
        (push && !pop): level_q <= level_q + LW'(1);
        (pop && !push): level_q <= level_q - LW'(1);
        default:        level_q <= level_q;
      endcase
    end
  end

  // A drop coinciding with clr is still recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      overflow <= drop;
      drop_cnt <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (!cnt_sat) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

`ifdef MY_RX_BUFFER_CSUM_EN
  rx_csum_t csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (clr) begin
      csum_q <= push ? CSUM_W'(in_data) : '0;
    end else if (push) begin
      csum_q <= csum_q + CSUM_W'(in_data);
    end
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_my_rx_buffer.sv
// Self-checking bench for my_rx_buffer: queue model plus directed literals.
// Build with or without MY_RX_BUFFER_CSUM_EN; expectations follow the macro.
module tb_my_rx_buffer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic [11:0]      in_data;
  logic             in_vld;
  logic [11:0]      out_data;
  logic             out_vld;
  logic             out_rdy;
  logic [LW-1:0]    level;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic             clr;
  logic [15:0]      csum;

  my_rx_buffer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_vld   (in_vld),
    .out_data (out_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .clr      (clr),
    .csum     (csum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of accepted beats plus counters.
  int unsigned q[$];
  int unsigned popped[$];
  bit          m_ovf;
  int unsigned m_drop;
  int unsigned m_csum;
  bit          m_pop, m_push, m_dropev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
      m_csum = 0;
    end else begin
      m_pop    = (q.size() != 0) && out_rdy;
      m_push   = in_vld && ((q.size() < DEPTH) || m_pop);
      m_dropev = in_vld && !m_push;
      if (m_pop) begin
        popped.push_back(q[0]);
        void'(q.pop_front());
      end
      if (clr) begin
        m_ovf  = 1'b0;
        m_drop = 0;
        m_csum = 0;
      end
      if (m_push) begin
        q.push_back(int'(in_data));
`ifdef MY_RX_BUFFER_CSUM_EN
        m_csum = (m_csum + int'(in_data)) % 65536;
`endif
      end
      if (m_dropev) begin
        m_ovf = 1'b1;
        if (m_drop < (2 ** CNT_W) - 1) m_drop++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", 32'(level), 32'(q.size()));
      chk("out_vld", 32'(out_vld), 32'(q.size() != 0));
      chk("out_data", 32'(out_data), (q.size() != 0) ? q[0] : 0);
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_cnt", 32'(drop_cnt), m_drop);
      chk("csum", 32'(csum), m_csum);
    end
  end

  task automatic drive(logic v, logic [11:0] d, logic r, logic c);
    in_vld  = v;
    in_data = d;
    out_rdy = r;
    clr     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_vld = 1'b0;
    out_rdy = 1'b0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 12'h000, 1'b1, 1'b0);
  endtask

  initial begin
    in_data = '0;
    do_reset();
    chk_en = 1'b1;

    // Reset mid-stream at level 5
    for (int i = 0; i < 5; i++) drive(1'b1, 12'(i + 1), 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_csum", 32'(csum), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 12'h000, 1'b0, 1'b0);
    chk("post_rst_level", 32'(level), 32'd0);

    // Single beat
    drive(1'b1, 12'hABC, 1'b0, 1'b0);
    chk("single_vld", 32'(out_vld), 32'd1);
    chk("single_data", 32'(out_data), 32'hABC);
    chk("single_level", 32'(level), 32'd1);
    drain();

    // Fill, overflow, ordered drain
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 12'(i), 1'b0, 1'b0);
    chk("fill_level", 32'(level), 32'd16);
    drive(1'b1, 12'h0FF, 1'b0, 1'b0);
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_drop", 32'(drop_cnt), 32'd1);
    chk("fill_level_hold", 32'(level), 32'd16);
    popped.delete();
    drain();
    chk("drain_cnt", 32'(popped.size()), 32'd16);
    for (int i = 0; i < DEPTH; i++)
      if (i < popped.size()) chk("drain_order", popped[i], 32'(i));

    // Full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 12'(16'h100 + i), 1'b0, 1'b0);
    popped.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 12'(16'h200 + i), 1'b1, 1'b0);
      chk("fullpop_level", 32'(level), 32'd16);
      chk("fullpop_drop", 32'(drop_cnt), 32'd1);
    end
    drain();
    chk("fullpop_cnt", 32'(popped.size()), 32'd20);
    if (popped.size() >= 20) begin
      chk("fullpop_first", popped[0], 32'h100);
      chk("fullpop_16", popped[16], 32'h200);
      chk("fullpop_last", popped[19], 32'h203);
    end

    // Streaming through pointer wrap
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 12'(16'h300 + i), 1'b1, 1'b0);
      chk("stream_vld", 32'(out_vld), 32'd1);
      chk("stream_data", 32'(out_data), 32'(16'h300 + i));
      chk("stream_level_le1", 32'(level <= 1), 32'd1);
    end
    drain();

    // clr after drops, then clr coincident with a drop
    chk("pre_clr_ovf", 32'(overflow), 32'd1);
    drive(1'b0, 12'h000, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 12'h055, 1'b0, 1'b0);
    drive(1'b1, 12'h066, 1'b0, 1'b0);
    drive(1'b1, 12'h077, 1'b0, 1'b0);
    chk("two_drops", 32'(drop_cnt), 32'd2);
    drive(1'b1, 12'h088, 1'b0, 1'b1);
    chk("clr_drop_ovf", 32'(overflow), 32'd1);
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd1);
    drain();

    // Checksum of 17 x 0xFFF from reset
    do_reset();
    for (int i = 0; i < 17; i++) drive(1'b1, 12'hFFF, 1'b1, 1'b0);
`ifdef MY_RX_BUFFER_CSUM_EN
    chk("csum_fff17", 32'(csum), 32'h0FEF);
`else
    chk("csum_off", 32'(csum), 32'h0000);
`endif
    drain();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 60),
            12'($urandom),
            ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 99) < 2));
    end
    drain();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
